// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared ROB entry/output types and default widths
package rob_commit_pkg;
    localparam int ROB_DEPTH  = 16;
    localparam int ROB_PC_W   = 32;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_DEST_W = 5;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  exc;
        logic [ROB_PC_W-1:0]   pc;
        logic [ROB_DEST_W-1:0] dest;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [ROB_PC_W-1:0]   pc;
        logic [ROB_DEST_W-1:0] dest;
        logic [ROB_DATA_W-1:0] data;
        logic                  exc;
    } rob_out_t;
endpackage

// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: head/tail pointers with wrap bit, full/empty/count
module rob_ptr_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inc_head,
    input  logic             inc_tail,
    output logic [IDX_W-1:0] head_idx,
    output logic [IDX_W-1:0] tail_idx,
    output logic             full,
    output logic             empty,
    output logic [IDX_W:0]   count
);
    logic [IDX_W:0] head, tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (inc_head) head <= head + 1'b1;
            if (inc_tail) tail <= tail + 1'b1;
        end
    end

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign empty    = head == tail;
    assign full     = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    assign count    = tail - head;
endmodule

// File: rtl/rob_commit_out.sv
// rob_commit_out: ROB entry array with dispatch, out-of-order writeback and in-order commit port
module rob_commit_out
    import rob_commit_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int PC_W   = ROB_PC_W,
    parameter int DATA_W = ROB_DATA_W,
    parameter int DEST_W = ROB_DEST_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [PC_W-1:0]          alloc_pc,
    input  logic [DEST_W-1:0]        alloc_dest,
    output logic [$clog2(DEPTH)-1:0] alloc_id,
    input  logic                     wb_valid,
    input  logic [$clog2(DEPTH)-1:0] wb_id,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     wb_exc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH)-1:0] out_id,
    output logic [PC_W-1:0]          out_pc,
    output logic [DEST_W-1:0]        out_dest,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_exc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wb_err
);
    localparam int IDX_W = $clog2(DEPTH);

    rob_entry_t ent [DEPTH];
    rob_entry_t head_e, wb_e;
    rob_out_t   o;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic full, empty, alloc_fire, wb_ok, commit;

    rob_ptr_ctrl #(.IDX_W(IDX_W)) u_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .inc_head (commit),
        .inc_tail (alloc_fire),
        .head_idx (head_idx),
        .tail_idx (tail_idx),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign head_e      = ent[head_idx];
    assign wb_e        = ent[wb_id];
    assign alloc_ready = !full;
    assign alloc_id    = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign wb_ok       = wb_valid && wb_e.valid && !wb_e.done;
    assign o           = '{valid: !empty && head_e.valid && head_e.done, pc: head_e.pc,
                           dest: head_e.dest, data: head_e.data, exc: head_e.exc};
    assign commit      = o.valid && out_ready;
    assign out_valid   = o.valid;
    assign out_id      = head_idx;
    assign out_pc      = o.pc;
    assign out_dest    = o.dest;
    assign out_data    = o.data;
    assign out_exc     = o.exc;

    // Commit, writeback and alloc never target the same entry in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            wb_err <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].done  <= 1'b0;
            end
        end else begin
            if (commit) begin
                ent[head_idx].valid <= 1'b0;
                ent[head_idx].done  <= 1'b0;
            end
            if (wb_ok) begin
                ent[wb_id].done <= 1'b1;
                ent[wb_id].data <= wb_data;
                ent[wb_id].exc  <= wb_exc;
            end else if (wb_valid) begin
                wb_err <= 1'b1;
            end
            if (alloc_fire)
                ent[tail_idx] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0, pc: alloc_pc,
                                   dest: alloc_dest, data: '0};
        end
    end
endmodule

// File: tb/tb_rob_commit_out.sv
// tb_rob_commit_out: table vectors, corner sequences and random traffic against a queue model
module tb_rob_commit_out;
    logic        clk = 0, rst_n = 0, flush = 0;
    logic        alloc_valid = 0, alloc_ready;
    logic [31:0] alloc_pc = 0;
    logic [4:0]  alloc_dest = 0;
    logic [3:0]  alloc_id;
    logic        wb_valid = 0;
    logic [3:0]  wb_id = 0;
    logic [31:0] wb_data = 0;
    logic        wb_exc = 0;
    logic        out_valid, out_ready = 0;
    logic [3:0]  out_id;
    logic [31:0] out_pc, out_data;
    logic [4:0]  out_dest;
    logic        out_exc;
    logic [4:0]  count;
    logic        wb_err;

    rob_commit_out dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_dest(alloc_dest), .alloc_id(alloc_id),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_exc(wb_exc),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_pc(out_pc),
        .out_dest(out_dest), .out_data(out_data), .out_exc(out_exc),
        .count(count), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // In-flight instructions in program order; front is the oldest
    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        done;
        logic [31:0] data;
        logic        exc;
    } m_t;
    m_t   q[$];
    int   m_tail;
    logic m_err;

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        m_err  = 0;
    endtask

    task automatic check_model();
        logic ov;
        ov = q.size() > 0 && q[0].done;
        chk("count", count, q.size());
        chk("alloc_ready", alloc_ready, q.size() < 16);
        chk("alloc_id", alloc_id, m_tail);
        chk("out_valid", out_valid, ov);
        chk("out_id", out_id, q.size() > 0 ? q[0].id : m_tail);
        chk("wb_err", wb_err, m_err);
        if (ov) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_dest", out_dest, q[0].dest);
            chk("out_data", out_data, q[0].data);
            chk("out_exc", out_exc, q[0].exc);
        end
    endtask

    // Called just after a falling edge: drive, check, update model, advance one cycle
    task automatic cycle(input logic av, input logic [31:0] pc, input logic [4:0] dst,
                         input logic wv, input int wid, input logic [31:0] wd, input logic we,
                         input logic ordy, input logic fl);
        logic c, a;
        int   hit;
        alloc_valid = av; alloc_pc = pc; alloc_dest = dst;
        wb_valid = wv; wb_id = wid[3:0]; wb_data = wd; wb_exc = we;
        out_ready = ordy; flush = fl;
        #1;
        check_model();
        if (fl) begin
            q.delete();
            m_tail = 0;
        end else begin
            c = q.size() > 0 && q[0].done && ordy;
            a = av && q.size() < 16;
            if (wv) begin
                hit = -1;
                foreach (q[j]) if (q[j].id == (wid & 15) && !q[j].done) hit = j;
                if (hit >= 0) begin
                    q[hit].done = 1;
                    q[hit].data = wd;
                    q[hit].exc  = we;
                end else m_err = 1;
            end
            if (c) void'(q.pop_front());
            if (a) begin
                q.push_back('{id: m_tail, pc: pc, dest: dst, done: 0, data: 0, exc: 0});
                m_tail = (m_tail + 1) % 16;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(0, 0, 0, 0, 0, 0, 0, ordy, 0);
    endtask

    task automatic alloc(input logic [31:0] pc);
        cycle(1, pc, pc[6:2], 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wb(input int wid, input logic [31:0] wd, input logic we);
        cycle(0, 0, 0, 1, wid, wd, we, 0, 0);
    endtask

    typedef struct {
        logic        av;
        logic [31:0] pc;
        logic        wv;
        int          wid;
        logic [31:0] wd;
        logic        ordy;
        int          e_cnt;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_data;
        int          e_aid;
    } vec_t;
    vec_t tv[11];

    initial begin
        tv[0]  = '{1, 32'h100, 0, 0, 0,     0, 0, 0, 0,      0,     0};
        tv[1]  = '{1, 32'h104, 0, 0, 0,     0, 1, 0, 0,      0,     1};
        tv[2]  = '{1, 32'h108, 0, 0, 0,     0, 2, 0, 0,      0,     2};
        tv[3]  = '{0, 0,       1, 2, 'hC2,  0, 3, 0, 0,      0,     3};
        tv[4]  = '{0, 0,       1, 0, 'hA0,  0, 3, 0, 0,      0,     3};
        tv[5]  = '{0, 0,       0, 0, 0,     1, 3, 1, 'h100,  'hA0,  3};
        tv[6]  = '{0, 0,       0, 0, 0,     1, 2, 0, 0,      0,     3};
        tv[7]  = '{0, 0,       1, 1, 'hB1,  1, 2, 0, 0,      0,     3};
        tv[8]  = '{0, 0,       0, 0, 0,     1, 2, 1, 'h104,  'hB1,  3};
        tv[9]  = '{0, 0,       0, 0, 0,     1, 1, 1, 'h108,  'hC2,  3};
        tv[10] = '{0, 0,       0, 0, 0,     0, 0, 0, 0,      0,     3};

        model_reset();
        #12 rst_n = 1;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wb_err", wb_err, 0);

        for (int i = 0; i < 11; i++) begin
            chk($sformatf("tv%0d_count", i), count, tv[i].e_cnt);
            chk($sformatf("tv%0d_out_valid", i), out_valid, tv[i].e_ov);
            chk($sformatf("tv%0d_alloc_id", i), alloc_id, tv[i].e_aid);
            if (tv[i].e_ov) begin
                chk($sformatf("tv%0d_out_pc", i), out_pc, tv[i].e_pc);
                chk($sformatf("tv%0d_out_data", i), out_data, tv[i].e_data);
            end
            cycle(tv[i].av, tv[i].pc, tv[i].pc[6:2], tv[i].wv, tv[i].wid, tv[i].wd, 0,
                  tv[i].ordy, 0);
        end

        chk("pre_err", wb_err, 0);
        wb(7, 32'h77, 0);
        chk("err_unalloc", wb_err, 1);
        alloc(32'h200);
        wb(3, 32'h33, 1);
        wb(3, 32'h44, 0);
        chk("err_sticky", wb_err, 1);
        chk("err_entry_data", out_data, 32'h33);

        alloc(32'h204);
        alloc(32'h208);
        wb(4, 32'h55, 0);
        wb(5, 32'h66, 1);
        for (int i = 0; i < 5; i++) idle(0);
        chk("hold_count", count, 3);
        chk("hold_pc", out_pc, 32'h200);
        for (int i = 0; i < 4; i++) idle(1);
        chk("drained", count, 0);

        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) alloc(32'h1000 + 4 * i);
        chk("full_ready", alloc_ready, 0);
        chk("full_count", count, 16);
        wb(0, 32'hD0, 0);
        cycle(1, 32'h2000, 1, 0, 0, 0, 0, 1, 0);
        chk("after_commit_ready", alloc_ready, 1);
        chk("after_commit_id", alloc_id, 0);
        chk("after_commit_count", count, 15);

        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) alloc(32'h3000 + 4 * i);
        wb(0, 32'hE0, 0);
        cycle(1, 32'h4000, 2, 1, 5, 32'hE5, 0, 1, 1);
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_alloc_id", alloc_id, 0);
        chk("flush_wb_err", wb_err, 1);

        for (int i = 0; i < 4; i++) alloc(32'h5000 + 4 * i);
        wb(0, 32'h1, 0);
        alloc_valid = 1; out_ready = 1;
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("arst_count", count, 0);
        chk("arst_alloc_ready", alloc_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_alloc_id", alloc_id, 0);
        chk("arst_out_id", out_id, 0);
        chk("arst_out_pc", out_pc, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_wb_err", wb_err, 0);
        @(negedge clk);
        rst_n = 1;

        for (int n = 0; n < 600; n++) begin
            int wid;
            wid = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                  q[$urandom_range(0, q.size() - 1)].id : int'($urandom_range(0, 15));
            cycle($urandom_range(0, 9) < 6, $urandom, 5'($urandom),
                  $urandom_range(0, 1), wid, $urandom, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
